// File: rtl/rll_key_load_ctrl.sv
// Key load controller for RLL-locked netlists: beat-wise key load,
// XOR-fold tag check, registered key drive and fail lockout.
module rll_key_load_ctrl #(
  parameter int KEY_WIDTH = 32,
  parameter int CHUNK     = 8,
  parameter int MAX_FAILS = 3,
  localparam int NBEATS   = KEY_WIDTH / CHUNK,
  localparam int BW       = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int FW       = $clog2(MAX_FAILS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHUNK-1:0]     chunk_data,
  input  logic                 chunk_valid,
  output logic                 chunk_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 fail,
  output logic                 locked_out,
  output logic [FW-1:0]        fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TAG,
    S_ACTIVE,
    S_LOCK
  } state_t;

  state_t               state, state_nx;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CHUNK-1:0]     acc;
  logic [BW-1:0]        beat_cnt;
  logic                 xfer;
  logic                 tag_ok;
  logic                 last_beat;
  logic                 restart;
  logic [FW-1:0]        fc_inc;

  assign busy        = (state == S_LOAD) || (state == S_TAG);
  assign chunk_ready = busy;
  assign locked_out  = (state == S_LOCK);

  always_comb begin
    xfer      = chunk_valid && chunk_ready && !abort;
    tag_ok    = (chunk_data == acc);
    last_beat = (beat_cnt == BW'(NBEATS - 1));
    restart   = start && ((state == S_IDLE) || (state == S_ACTIVE));
    fc_inc    = (fail_count == FW'(MAX_FAILS)) ? fail_count
                                               : fail_count + FW'(1);
    state_nx  = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (abort)                  state_nx = S_IDLE;
        else if (xfer && last_beat) state_nx = S_TAG;
      end
      S_TAG: begin
        if (abort)       state_nx = S_IDLE;
        else if (xfer) begin
          if (tag_ok)                         state_nx = S_ACTIVE;
          else if (fc_inc == FW'(MAX_FAILS)) state_nx = S_LOCK;
          else                                state_nx = S_IDLE;
        end
      end
      S_ACTIVE: if (start) state_nx = S_LOAD;
      S_LOCK:   state_nx = S_LOCK;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shadow     <= '0;
      acc        <= '0;
      beat_cnt   <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
    end else begin
      state <= state_nx;
      fail  <= 1'b0;
      if (restart || (abort && busy)) begin
        shadow   <= '0;
        acc      <= '0;
        beat_cnt <= '0;
      end
      if ((state == S_LOAD) && xfer) begin
        shadow[int'(beat_cnt)*CHUNK +: CHUNK] <= chunk_data;
        acc      <= acc ^ chunk_data;
        beat_cnt <= beat_cnt + BW'(1);
      end
      if ((state == S_TAG) && xfer) begin
        if (tag_ok) begin
          key_out    <= shadow;
          key_valid  <= 1'b1;
          fail_count <= '0;
        end else begin
          fail       <= 1'b1;
          fail_count <= fc_inc;
        end
      end
      // Drop the old key before any reload beat is taken.
      if ((state == S_ACTIVE) && start) begin
        key_out   <= '0;
        key_valid <= 1'b0;
      end
    end
  end

endmodule
